// File: rtl/outbound_buffer.sv
// Per-port outbound packet FIFO plus a byte-serial link transmitter (MSB first).
// Define OB_BYPASS_EN to let a packet skip the empty FIFO and go straight to the shifter.
module outbound_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pkt_in,
  input  logic        pkt_in_avail,
  output logic        ready_to_recv,
  input  logic        free_outbound,
  output logic        put_outbound,
  output logic [7:0]  payload_outbound
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [0:0]    r_state;
  logic [31:0]   r_shreg;
  logic [1:0]    r_bytecnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_fifo_wr;
  logic w_start;
  logic w_bypass;

  assign w_full        = (r_count == FULL_CNT);
  assign w_empty       = (r_count == '0);
  assign ready_to_recv = !w_full;
  assign w_push        = pkt_in_avail && ready_to_recv;

  // free_outbound only matters at a packet boundary: in IDLE or on the last byte.
  assign w_start = free_outbound && !w_empty &&
                   ((r_state == S_IDLE) || (r_bytecnt == 2'd3));

`ifdef OB_BYPASS_EN
  assign w_bypass = (r_state == S_IDLE) && w_empty && free_outbound && w_push;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fifo_wr = w_push && !w_bypass;

  assign put_outbound     = (r_state == S_SEND);
  assign payload_outbound = (r_state == S_SEND) ? r_shreg[31:24] : 8'h00;

  always_ff @(posedge clock) begin
    if (w_fifo_wr) begin
      r_mem[r_wptr] <= pkt_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_start) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_fifo_wr, w_start})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bytecnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_shreg   <= r_mem[r_rptr];
            r_bytecnt <= '0;
            r_state   <= S_SEND;
          end else if (w_bypass) begin
            r_shreg   <= pkt_in;
            r_bytecnt <= '0;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (r_bytecnt == 2'd3) begin
            // Reload on the last byte keeps consecutive packets gap-free.
            if (w_start) begin
              r_shreg   <= r_mem[r_rptr];
              r_bytecnt <= '0;
            end else begin
              r_shreg   <= '0;
              r_bytecnt <= '0;
              r_state   <= S_IDLE;
            end
          end else begin
            r_shreg   <= {r_shreg[23:0], 8'h00};
            r_bytecnt <= r_bytecnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_outbound_buffer.sv
// Scoreboard bench for outbound_buffer: expected link bytes are queued on each accepted push.
// Honours OB_BYPASS_EN for the first-byte latency expectation.
module tb_outbound_buffer;

  logic        clock;
  logic        reset_n;
  logic [31:0] pkt_in;
  logic        pkt_in_avail;
  logic        ready_to_recv;
  logic        free_outbound;
  logic        put_outbound;
  logic [7:0]  payload_outbound;

  int errors = 0;
  int checks = 0;
  logic [7:0] expQ [$];

  outbound_buffer #(.DEPTH(4)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .pkt_in           (pkt_in),
    .pkt_in_avail     (pkt_in_avail),
    .ready_to_recv    (ready_to_recv),
    .free_outbound    (free_outbound),
    .put_outbound     (put_outbound),
    .payload_outbound (payload_outbound)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every transmitted byte must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset_n && put_outbound) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL link_byte: got unexpected byte %h, expected no traffic", payload_outbound);
      end else begin
        logic [7:0] e;
        e = expQ.pop_front();
        if (payload_outbound !== e) begin
          errors++;
          $display("[TB] FAIL link_byte: got %h expected %h", payload_outbound, e);
        end
      end
    end
  end

  // Called just after a rising edge; holds the packet for one cycle.
  task automatic push(input logic [31:0] p, output bit accepted);
    pkt_in       = p;
    pkt_in_avail = 1'b1;
    #1;
    accepted = ready_to_recv;
    @(posedge clock); #1;
    pkt_in_avail = 1'b0;
    if (accepted) begin
      expQ.push_back(p[31:24]);
      expQ.push_back(p[23:16]);
      expQ.push_back(p[15:8]);
      expQ.push_back(p[7:0]);
    end
  endtask

  task automatic measure_burst(input int budget, output int waited, output int burst);
    waited = 0;
    burst  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (put_outbound) break;
      waited++;
    end
    if (put_outbound) begin
      burst = 1;
      for (int i = 0; i < 64; i++) begin
        @(negedge clock);
        if (!put_outbound) break;
        burst++;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (expQ.size() == 0 && !put_outbound) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    pkt_in        = '0;
    pkt_in_avail  = 1'b0;
    free_outbound = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (ready_to_recv !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_to_recv);
    end
    checks++;
    if (put_outbound !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_put: got %b expected 0", put_outbound);
    end
    checks++;
    if (payload_outbound !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_payload: got %h expected 00", payload_outbound);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    bit acc;
    int waited, burst, expWait;
`ifdef OB_BYPASS_EN
    expWait = 0;
`else
    expWait = 1;
`endif
    free_outbound = 1'b1;
    push(32'hA1B2C3D4, acc);
    measure_burst(20, waited, burst);
    checks++;
    if (waited !== expWait) begin
      errors++; $display("[TB] FAIL single_latency: got %0d idle cycles expected %0d", waited, expWait);
    end
    checks++;
    if (burst !== 4) begin
      errors++; $display("[TB] FAIL single_length: got %0d expected 4", burst);
    end
    @(negedge clock);
    checks++;
    if (payload_outbound !== 8'h00) begin
      errors++; $display("[TB] FAIL idle_payload: got %h expected 00", payload_outbound);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_full();
    bit acc;
    int waited, burst;
    free_outbound = 1'b0;
    push(32'h11223344, acc);
    push(32'h55667788, acc);
    push(32'h99AABBCC, acc);
    push(32'h0F1E2D3C, acc);
    @(negedge clock);
    checks++;
    if (ready_to_recv !== 1'b0) begin
      errors++; $display("[TB] FAIL full_ready: got %b expected 0", ready_to_recv);
    end
    @(posedge clock); #1;
    push(32'hDEADBEEF, acc);
    checks++;
    if (acc !== 1'b0) begin
      errors++; $display("[TB] FAIL full_drop: got accepted=%b expected 0", acc);
    end
    free_outbound = 1'b1;
    measure_burst(20, waited, burst);
    checks++;
    if (burst !== 16) begin
      errors++; $display("[TB] FAIL full_drain_len: got %0d expected 16", burst);
    end
    checks++;
    if (expQ.size() !== 0) begin
      errors++; $display("[TB] FAIL full_drain_left: got %0d bytes pending expected 0", expQ.size());
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int waited, burst;
    free_outbound = 1'b0;
    push(32'h01020304, acc);
    push(32'hF0E0D0C0, acc);
    free_outbound = 1'b1;
    measure_burst(20, waited, burst);
    checks++;
    if (burst !== 8) begin
      errors++; $display("[TB] FAIL b2b_len: got %0d expected 8", burst);
    end
  endtask

  task automatic test_free_drop();
    bit acc;
    int waited, burst, puts;
    free_outbound = 1'b0;
    push(32'h13579BDF, acc);
    push(32'h2468ACE0, acc);
    free_outbound = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    free_outbound = 1'b0;
    measure_burst(4, waited, burst);
    checks++;
    if (waited !== 0 || burst !== 3) begin
      errors++; $display("[TB] FAIL drop_rest: got wait=%0d len=%0d expected wait=0 len=3", waited, burst);
    end
    puts = 0;
    repeat (3) begin
      @(negedge clock);
      if (put_outbound) puts++;
      @(posedge clock); #1;
    end
    checks++;
    if (puts !== 0) begin
      errors++; $display("[TB] FAIL drop_hold: got %0d put cycles expected 0", puts);
    end
    free_outbound = 1'b1;
    measure_burst(20, waited, burst);
    checks++;
    if (waited !== 1 || burst !== 4) begin
      errors++; $display("[TB] FAIL drop_resume: got wait=%0d len=%0d expected wait=1 len=4", waited, burst);
    end
  endtask

  task automatic test_full_pop_push();
    bit acc1, acc2, ok;
    free_outbound = 1'b0;
    push(32'hAA000001, acc1);
    push(32'hAA000002, acc1);
    push(32'hAA000003, acc1);
    push(32'hAA000004, acc1);
    free_outbound = 1'b1;
    push(32'h5A5A5A5A, acc1);
    push(32'h5A5A5A5A, acc2);
    checks++;
    if (acc1 !== 1'b0) begin
      errors++; $display("[TB] FAIL popcycle_refuse: got accepted=%b expected 0", acc1);
    end
    checks++;
    if (acc2 !== 1'b1) begin
      errors++; $display("[TB] FAIL popcycle_retry: got accepted=%b expected 1", acc2);
    end
    @(negedge clock);
    checks++;
    if (ready_to_recv !== 1'b0) begin
      errors++; $display("[TB] FAIL popcycle_refull: got %b expected 0", ready_to_recv);
    end
    @(posedge clock); #1;
    wait_idle(80, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL popcycle_drain: got %0d bytes pending expected 0", expQ.size());
    end
  endtask

  task automatic test_reset_mid();
    bit acc, seen;
    int puts;
    free_outbound = 1'b0;
    push(32'hC0FFEE11, acc);
    push(32'hC0FFEE22, acc);
    push(32'hC0FFEE33, acc);
    free_outbound = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (put_outbound) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL rstmid_start: got no byte expected byte 0");
    end
    @(negedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (put_outbound !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_put: got %b expected 0", put_outbound);
    end
    checks++;
    if (ready_to_recv !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_ready: got %b expected 1", ready_to_recv);
    end
    expQ.delete();
    @(posedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
    puts = 0;
    repeat (10) begin
      @(negedge clock);
      if (put_outbound) puts++;
    end
    checks++;
    if (puts !== 0) begin
      errors++; $display("[TB] FAIL rstmid_stale: got %0d put cycles expected 0", puts);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    $display("[TB] outbound_buffer bench start");
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_free_drop();
    test_full_pop_push();
    test_reset_mid();
    checks++;
    if (expQ.size() !== 0) begin
      errors++; $display("[TB] FAIL final_queue: got %0d bytes pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
